axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter SramAddrWidth, default 16, giving the SRAM word-address width in 64-bit words.
REQ-002 SHALL have parameter ResetSramPrio, default 0, giving the first arbitration winner after reset (0=read, 1=write).
REQ-003 SHALL have port clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port axi_req_i  in  ariane_axi::req_slv_t  AXI slave request from the crossbar.
REQ-006 SHALL have port axi_resp_o  out  ariane_axi::resp_slv_t  AXI slave response.
REQ-007 SHALL have port req_o  out  1  SRAM access strobe.
REQ-008 SHALL have port we_o  out  1  SRAM write enable.
REQ-009 SHALL have port addr_o  out  SramAddrWidth  SRAM word address, equal to AXI addr[SramAddrWidth+2:3].
REQ-010 SHALL have port wdata_o  out  64  SRAM write data.
REQ-011 SHALL have port be_o  out  8  SRAM byte enables.
REQ-012 SHALL have port rdata_i  in  64  SRAM read data, valid exactly one cycle after a read strobe.

Function
REQ-013 SHALL process one AXI transaction at a time using FSM states IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
REQ-014 In IDLE, SHALL accept one request per handshake:
- ar_ready=1 or aw_ready=1, never both in the same cycle.
- When ar_valid and aw_valid are both high, the winner alternates and the last winner is recorded in a priority flop.
REQ-015 On AR handshake, SHALL latch id, addr, len, size and burst, clear the beat counter, and go to RD_REQ.
REQ-016 In RD_REQ, SHALL drive req_o=1, we_o=0 and the current address for one cycle, then go to RD_DATA.
REQ-017 In RD_DATA, SHALL hold r_valid=1 with rdata registered on the first RD_DATA cycle, plus the latched id, resp=OKAY and last=(beat==len).
- Holds r_valid until r_ready.
- On handshake: if last, go to IDLE; otherwise advance the address and go to RD_REQ.
- Max read throughput is one beat per 2 cycles.
REQ-018 On AW handshake, SHALL latch id, addr, len, size, burst and atop, and go to WR_DATA.
REQ-019 In WR_DATA, SHALL set w_ready=1 and, for each w_valid cycle, issue the SRAM write in the same cycle:
- req_o=1, we_o=1, wdata_o=w.data, be_o=w.strb.
- The address advances after each beat.
REQ-020 When atop!=0, SHALL consume the W beats with req_o=0 and record an error flag.
REQ-021 SHALL leave WR_DATA for WR_RESP on the beat with w.last=1, or when beat==len (whichever comes first); the beat count is not checked against w.last otherwise.
REQ-022 In WR_RESP, SHALL hold b_valid=1 with the latched id and resp (SLVERR=2'b10 if the error flag is set, else OKAY) until b_ready, then go to IDLE.
REQ-023 Address advance rules:
- INCR: add (1<<size), with natural wrap at 64 bits.
- FIXED: no change.
- WRAP: treated as INCR.
REQ-024 Beat counter SHALL be 8 bits wide and compared against len (0..255, giving 1..256 beats).
REQ-025 SHALL keep req_o=0 in IDLE, RD_DATA and WR_RESP, and whenever WR_DATA has w_valid=0.
REQ-026 SHALL drive r/b user fields to 0 and ignore ar/aw user, lock, cache, prot, qos and region.
REQ-027 SHALL never assert w_ready outside WR_DATA; W beats arriving early stall.

Reset
REQ-028 On rst_i=1, SHALL asynchronously reset:
- FSM to IDLE, beat counter to 0, error flag to 0, priority flop to ResetSramPrio.
- All latched request fields to 0.
REQ-029 During and after reset, outputs SHALL be zero except the IDLE readies: req_o=0, we_o=0, r_valid=0, b_valid=0, w_ready=0.
REQ-030 Reset asserted mid-burst SHALL abort the transaction without emitting a response; the upstream is reset in the same domain.

Structure
REQ-031 SHALL reuse ariane_axi::req_slv_t and resp_slv_t, and axi_pkg burst/resp constants; no new package types are required.
REQ-032 FSM state enum SHALL be local to the module.
REQ-033 Address-advance logic SHALL be one combinational sub-module, axi_sram_addr_gen (inputs addr, size, burst; output next addr).

Verification
REQ-034 Single read: AR addr=0x40, len=0, size=3, id=5; SRAM word 8 holds 0xDEADBEEF -> addr_o=8 strobe, then R data=0xDEADBEEF, id=5, last=1, resp=OKAY.
REQ-035 INCR write burst: AW addr=0x100, len=3, size=3; 4 W beats with strb=0xFF -> SRAM writes at words 0x20..0x23, then one B with OKAY.
REQ-036 Simultaneous AR+AW in IDLE for three consecutive transactions starting from reset -> service order read, write, read (ResetSramPrio=0).
REQ-037 Backpressure: r_ready low for 5 cycles on beat 1 of a len=1 read -> r_valid and data stable throughout, no extra SRAM strobe.
REQ-038 Atomic: AW atop=6'h20, len=0 -> W consumed, req_o stays 0, B resp=SLVERR.
REQ-039 Reset mid-burst: rst_i pulsed during beat 2 of a len=7 write -> all outputs 0, FSM back in IDLE, next AR served normally.

Source files
------------

// File: rtl/ariane_axi.sv
// Subset of the Ariane AXI channel structs used on the crossbar slave side.
package ariane_axi;
    localparam int unsigned IdWidthSlave = 5;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned UserWidth    = 1;

    typedef logic [IdWidthSlave-1:0] id_slv_t;
    typedef logic [AddrWidth-1:0]    addr_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [DataWidth/8-1:0]  strb_t;
    typedef logic [UserWidth-1:0]    user_t;

    typedef struct packed {
        id_slv_t          id;
        addr_t            addr;
        axi_pkg::len_t    len;
        axi_pkg::size_t   size;
        axi_pkg::burst_t  burst;
        logic             lock;
        axi_pkg::cache_t  cache;
        axi_pkg::prot_t   prot;
        axi_pkg::qos_t    qos;
        axi_pkg::region_t region;
        axi_pkg::atop_t   atop;
        user_t            user;
    } aw_chan_slv_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_slv_t        id;
        axi_pkg::resp_t resp;
        user_t          user;
    } b_chan_slv_t;

    typedef struct packed {
        id_slv_t          id;
        addr_t            addr;
        axi_pkg::len_t    len;
        axi_pkg::size_t   size;
        axi_pkg::burst_t  burst;
        logic             lock;
        axi_pkg::cache_t  cache;
        axi_pkg::prot_t   prot;
        axi_pkg::qos_t    qos;
        axi_pkg::region_t region;
        user_t            user;
    } ar_chan_slv_t;

    typedef struct packed {
        id_slv_t        id;
        data_t          data;
        axi_pkg::resp_t resp;
        logic           last;
        user_t          user;
    } r_chan_slv_t;

    typedef struct packed {
        aw_chan_slv_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        ar_chan_slv_t ar;
        logic         ar_valid;
        logic         r_ready;
    } req_slv_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        b_chan_slv_t  b;
        logic         r_valid;
        r_chan_slv_t  r;
    } resp_slv_t;
endpackage

// File: rtl/axi_pkg.sv
// Subset of the AXI type and constant definitions that the SRAM slave relies on.
package axi_pkg;
    typedef logic [1:0] burst_t;
    typedef logic [1:0] resp_t;
    typedef logic [2:0] size_t;
    typedef logic [7:0] len_t;
    typedef logic [5:0] atop_t;
    typedef logic [3:0] cache_t;
    typedef logic [2:0] prot_t;
    typedef logic [3:0] qos_t;
    typedef logic [3:0] region_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;
    localparam resp_t  RESP_OKAY   = 2'b00;
    localparam resp_t  RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_sram_slave_pkg.sv
// Block-level constants and helpers shared by the SRAM slave and its address generator.
package axi_sram_slave_pkg;
    localparam int unsigned BeatCntWidth = 8;

    function automatic logic [63:0] beat_bytes(input axi_pkg::size_t size);
        return 64'd1 << size;
    endfunction
endpackage

// File: rtl/axi_sram_slave_addr_gen.sv
// Next-beat byte address for an AXI burst.
module axi_sram_addr_gen
    import axi_pkg::*;
    import axi_sram_slave_pkg::*;
(
    input  logic [63:0] addr_i,
    input  size_t       size_i,
    input  burst_t      burst_i,
    output logic [63:0] next_addr_o
);
    // WRAP advances like INCR: no wrap boundary is applied.
    always_comb begin
        case (burst_i)
            BURST_FIXED:            next_addr_o = addr_i;
            BURST_INCR, BURST_WRAP: next_addr_o = addr_i + beat_bytes(size_i);
            default:                next_addr_o = addr_i + beat_bytes(size_i);
        endcase
    end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one transaction at a time onto a single-port 64-bit SRAM.
module axi_sram_slave
    import axi_pkg::*;
    import axi_sram_slave_pkg::*;
#(
    parameter int unsigned SramAddrWidth = 16,
    parameter bit          ResetSramPrio = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  ariane_axi::req_slv_t     axi_req_i,
    output ariane_axi::resp_slv_t    axi_resp_o,
    output logic                     req_o,
    output logic                     we_o,
    output logic [SramAddrWidth-1:0] addr_o,
    output logic [63:0]              wdata_o,
    output logic [7:0]               be_o,
    input  logic [63:0]              rdata_i
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_e;

    state_e                  state_q, state_d;
    ariane_axi::id_slv_t     id_q, id_d;
    logic [63:0]             addr_q, addr_d, addr_next;
    len_t                    len_q, len_d;
    size_t                   size_q, size_d;
    burst_t                  burst_q, burst_d;
    atop_t                   atop_q, atop_d;
    logic [BeatCntWidth-1:0] beat_q, beat_d;
    logic                    err_q, err_d;
    logic                    prio_q, prio_d;   // 1: write wins the next AR/AW collision
    logic                    rd_first_q;
    logic [63:0]             rdata_q;
    logic                    grant_rd, grant_wr, last_beat;
    logic                    unused_ok;

    assign unused_ok = ^{axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                         axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                         axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                         axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                         axi_req_i.w.user};

    axi_sram_addr_gen i_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (addr_next)
    );

    assign grant_rd  = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_q);
    assign grant_wr  = axi_req_i.aw_valid && (!axi_req_i.ar_valid ||  prio_q);
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            atop_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            prio_q     <= ResetSramPrio;
            rd_first_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            atop_q     <= atop_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            prio_q     <= prio_d;
            rd_first_q <= (state_q == RD_REQ);
            // SRAM data is only valid in the cycle after the strobe; hold it for stalls.
            if (rd_first_q) rdata_q <= rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        atop_d  = atop_q;
        beat_d  = beat_q;
        err_d   = err_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    id_d    = axi_req_i.ar.id;
                    addr_d  = axi_req_i.ar.addr;
                    len_d   = axi_req_i.ar.len;
                    size_d  = axi_req_i.ar.size;
                    burst_d = axi_req_i.ar.burst;
                    beat_d  = '0;
                    state_d = RD_REQ;
                    if (axi_req_i.aw_valid) prio_d = 1'b1;
                end else if (grant_wr) begin
                    id_d    = axi_req_i.aw.id;
                    addr_d  = axi_req_i.aw.addr;
                    len_d   = axi_req_i.aw.len;
                    size_d  = axi_req_i.aw.size;
                    burst_d = axi_req_i.aw.burst;
                    atop_d  = axi_req_i.aw.atop;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = WR_DATA;
                    if (axi_req_i.ar_valid) prio_d = 1'b0;
                end
            end
            RD_REQ: state_d = RD_DATA;
            RD_DATA: begin
                if (axi_req_i.r_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_next;
                        beat_d  = beat_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (axi_req_i.w_valid) begin
                    addr_d = addr_next;
                    beat_d = beat_q + 1'b1;
                    if (atop_q != '0) err_d = 1'b1;
                    if (axi_req_i.w.last || last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: if (axi_req_i.b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_resp_o = '0;
        req_o      = 1'b0;
        we_o       = 1'b0;
        wdata_o    = '0;
        be_o       = '0;
        addr_o     = addr_q[SramAddrWidth+2:3];
        case (state_q)
            IDLE: begin
                axi_resp_o.ar_ready = grant_rd;
                axi_resp_o.aw_ready = grant_wr;
            end
            RD_REQ: req_o = 1'b1;
            RD_DATA: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.id    = id_q;
                axi_resp_o.r.data  = rd_first_q ? rdata_i : rdata_q;
                axi_resp_o.r.resp  = RESP_OKAY;
                axi_resp_o.r.last  = last_beat;
            end
            WR_DATA: begin
                axi_resp_o.w_ready = 1'b1;
                // Atomics are drained without touching the SRAM.
                if (axi_req_i.w_valid && atop_q == '0) begin
                    req_o   = 1'b1;
                    we_o    = 1'b1;
                    wdata_o = axi_req_i.w.data;
                    be_o    = axi_req_i.w.strb;
                end
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = id_q;
                axi_resp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end
endmodule
